// File: rtl/usb_control_endpoint_if.sv
// Bundles the SETUP, IN-packet and descriptor-ROM signals of endpoint 0.
// slave is the endpoint sequencer; master is the transceiver/ROM side.
interface usb_control_endpoint_if;
  logic [3:0]  Setup_Endpoint;
  logic [7:0]  Setup_RequestType;
  logic [7:0]  Setup_Request;
  logic [15:0] Setup_Value;
  logic [15:0] Setup_Index;
  logic [15:0] Setup_Length;
  logic        Setup_Valid;
  logic        Setup_Ack;

  logic [9:0]  In_ByteCount;
  logic        In_Send;
  logic        In_Busy;
  logic        In_ClkEnable;
  logic [9:0]  In_Address;
  logic [7:0]  In_Data;

  logic [9:0]  Desc_Address;
  logic [7:0]  Desc_Data;

  modport slave (
    input  Setup_Endpoint, Setup_RequestType, Setup_Request, Setup_Value,
           Setup_Index, Setup_Length, Setup_Valid,
    output Setup_Ack,
    output In_ByteCount, In_Send, In_Data,
    input  In_Busy, In_ClkEnable, In_Address,
    output Desc_Address,
    input  Desc_Data
  );

  modport master (
    output Setup_Endpoint, Setup_RequestType, Setup_Request, Setup_Value,
           Setup_Index, Setup_Length, Setup_Valid,
    input  Setup_Ack,
    input  In_ByteCount, In_Send, In_Data,
    output In_Busy, In_ClkEnable, In_Address,
    input  Desc_Address,
    output Desc_Data
  );
endinterface

// File: rtl/usb_control_endpoint.sv
// Endpoint-0 control sequencer: decodes standard SETUP requests, drives the
// IN data/status stages in MAX_PACKET chunks, owns Address and Configuration.
module usb_control_endpoint #(
  parameter int MAX_PACKET       = 64,
  parameter int DEVICE_DESC_BASE = 0,
  parameter int DEVICE_DESC_LEN  = 18,
  parameter int CONFIG_DESC_BASE = 18,
  parameter int CONFIG_DESC_LEN  = 9
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Reset_Request,
  output logic [6:0]             Address,
  output logic [7:0]             Configuration,
  output logic                   Stall,
  usb_control_endpoint_if.slave  bus
);

  localparam logic [9:0] MAX_PKT  = 10'(MAX_PACKET);
  localparam logic [9:0] DEV_BASE = 10'(DEVICE_DESC_BASE);
  localparam logic [9:0] DEV_LEN  = 10'(DEVICE_DESC_LEN);
  localparam logic [9:0] CFG_BASE = 10'(CONFIG_DESC_BASE);
  localparam logic [9:0] CFG_LEN  = 10'(CONFIG_DESC_LEN);

  typedef enum logic [2:0] {IDLE, DECODE, LOAD, SEND, WAIT, STALL} state_t;
  typedef enum logic [2:0] {SRC_NONE, SRC_DEVICE, SRC_CONFIG_SET, SRC_CONFIG_REG, SRC_STATUS} source_t;

  state_t      state_reg, state_next;
  source_t     source_reg, source_next;
  logic [6:0]  address_reg, address_next;
  logic [6:0]  pending_addr_reg, pending_addr_next;
  logic        set_address_reg, set_address_next;
  logic [7:0]  config_reg, config_next;
  logic        setup_ack_reg, setup_ack_next;
  logic        in_send_reg, in_send_next;
  logic [9:0]  byte_count_reg, byte_count_next;
  logic        stall_reg, stall_next;
  logic [7:0]  req_type_reg, req_type_next;
  logic [7:0]  request_reg, request_next;
  logic [15:0] value_reg, value_next;
  logic [15:0] length_reg, length_next;
  logic [9:0]  base_reg, base_next;
  logic [9:0]  total_reg, total_next;
  logic [9:0]  remaining_reg, remaining_next;
  logic [9:0]  offset_reg, offset_next;

  logic        accept;
  logic        go_stall;
  logic [9:0]  src_len;
  logic        unused_inputs;

  // Setup_Ack is still high in the cycle after acceptance; masking it keeps a
  // slow-to-drop Setup_Valid from being accepted twice.
  assign accept = bus.Setup_Valid && (bus.Setup_Endpoint == 4'd0) && !setup_ack_reg;

  // Next-state and next-register computation for the whole sequencer.
  always_comb begin
    state_next        = state_reg;
    source_next       = source_reg;
    address_next      = address_reg;
    pending_addr_next = pending_addr_reg;
    set_address_next  = set_address_reg;
    config_next       = config_reg;
    setup_ack_next    = 1'b0;
    in_send_next      = in_send_reg;
    byte_count_next   = byte_count_reg;
    stall_next        = stall_reg;
    req_type_next     = req_type_reg;
    request_next      = request_reg;
    value_next        = value_reg;
    length_next       = length_reg;
    base_next         = base_reg;
    total_next        = total_reg;
    remaining_next    = remaining_reg;
    offset_next       = offset_reg;
    go_stall          = 1'b0;
    src_len           = 10'd0;

    if (accept) begin
      // A new SETUP always wins and abandons whatever transfer was running.
      setup_ack_next = 1'b1;
      req_type_next  = bus.Setup_RequestType;
      request_next   = bus.Setup_Request;
      value_next     = bus.Setup_Value;
      length_next    = bus.Setup_Length;
      stall_next     = 1'b0;
      in_send_next   = 1'b0;
      state_next     = DECODE;
    end else begin
      unique case (state_reg)
        IDLE: ;
        DECODE: begin
          set_address_next = 1'b0;
          source_next      = SRC_NONE;
          if (req_type_reg[6:5] != 2'd0) begin
            go_stall = 1'b1;
          end else begin
            case (request_reg)
              8'd6: begin
                case (value_reg[15:8])
                  8'd1: begin
                    source_next = SRC_DEVICE;
                    base_next   = DEV_BASE;
                    src_len     = DEV_LEN;
                  end
                  8'd2: begin
                    source_next = SRC_CONFIG_SET;
                    base_next   = CFG_BASE;
                    src_len     = CFG_LEN;
                  end
                  default: go_stall = 1'b1;
                endcase
              end
              8'd8: begin
                source_next = SRC_CONFIG_REG;
                src_len     = 10'd1;
              end
              8'd0: begin
                source_next = SRC_STATUS;
                src_len     = 10'd2;
              end
              8'd5: begin
                pending_addr_next = value_reg[6:0];
                set_address_next  = 1'b1;
              end
              8'd9: begin
                if (value_reg[7:0] <= 8'd1) config_next = value_reg[7:0];
                else                        go_stall    = 1'b1;
              end
              default: go_stall = 1'b1;
            endcase
          end

          if (go_stall) begin
            stall_next = 1'b1;
            state_next = STALL;
          end else begin
            total_next     = (length_reg < {6'd0, src_len}) ? length_reg[9:0] : src_len;
            remaining_next = total_next;
            offset_next    = 10'd0;
            state_next     = LOAD;
          end
        end
        LOAD: begin
          byte_count_next = (remaining_reg < MAX_PKT) ? remaining_reg : MAX_PKT;
          in_send_next    = 1'b1;
          if (in_send_reg && bus.In_Busy) begin
            in_send_next = 1'b0;
            state_next   = SEND;
          end
        end
        SEND: begin
          // Entered with In_Busy high, so a low sample here is its falling edge.
          if (!bus.In_Busy) begin
            offset_next    = offset_reg + byte_count_reg;
            remaining_next = remaining_reg - byte_count_reg;
            if (set_address_reg) address_next = pending_addr_reg;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (remaining_reg != 10'd0) begin
            state_next = LOAD;
          end else if ((byte_count_reg == MAX_PKT) && ({6'd0, total_reg} < length_reg)) begin
            // Short-of-wLength transfer ending on a full packet needs a ZLP;
            // LOAD naturally produces a count of zero here.
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end
        STALL: stall_next = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register; bus reset behaves exactly like Reset, so they share a branch.
  always_ff @(posedge Clk) begin
    if (Reset || Reset_Request) begin
      state_reg        <= IDLE;
      source_reg       <= SRC_NONE;
      address_reg      <= 7'd0;
      pending_addr_reg <= 7'd0;
      set_address_reg  <= 1'b0;
      config_reg       <= 8'd0;
      setup_ack_reg    <= 1'b0;
      in_send_reg      <= 1'b0;
      byte_count_reg   <= 10'd0;
      stall_reg        <= 1'b0;
      req_type_reg     <= 8'd0;
      request_reg      <= 8'd0;
      value_reg        <= 16'd0;
      length_reg       <= 16'd0;
      base_reg         <= 10'd0;
      total_reg        <= 10'd0;
      remaining_reg    <= 10'd0;
      offset_reg       <= 10'd0;
    end else begin
      state_reg        <= state_next;
      source_reg       <= source_next;
      address_reg      <= address_next;
      pending_addr_reg <= pending_addr_next;
      set_address_reg  <= set_address_next;
      config_reg       <= config_next;
      setup_ack_reg    <= setup_ack_next;
      in_send_reg      <= in_send_next;
      byte_count_reg   <= byte_count_next;
      stall_reg        <= stall_next;
      req_type_reg     <= req_type_next;
      request_reg      <= request_next;
      value_reg        <= value_next;
      length_reg       <= length_next;
      base_reg         <= base_next;
      total_reg        <= total_next;
      remaining_reg    <= remaining_next;
      offset_reg       <= offset_next;
    end
  end

  // Packet byte path: ROM address and data mux are combinational from In_Address.
  always_comb begin
    bus.Desc_Address = base_reg + offset_reg + bus.In_Address;
    case (source_reg)
      SRC_DEVICE, SRC_CONFIG_SET: bus.In_Data = bus.Desc_Data;
      SRC_CONFIG_REG:             bus.In_Data = config_reg;
      default:                    bus.In_Data = 8'h00;
    endcase
  end

  assign bus.Setup_Ack    = setup_ack_reg;
  assign bus.In_Send      = in_send_reg;
  assign bus.In_ByteCount = byte_count_reg;
  assign Address          = address_reg;
  assign Configuration    = config_reg;
  assign Stall            = stall_reg;

  // wIndex, the read strobe and the non-type bits of bmRequestType carry no meaning here.
  assign unused_inputs = ^{bus.Setup_Index, bus.In_ClkEnable, req_type_reg[7], req_type_reg[4:0]};

endmodule
